// File: rtl/imem_stream_loader_if.sv
// ---------------------------------------------------------------------------
// imem_stream_loader_if
//   Bundles the loader stream port and the instruction fetch port of
//   imem_stream_loader.
//
//   Handshake (loader port): a word moves on a rising edge where
//   ld_valid && ld_ready. ld_valid, ld_data and ld_last are driven by the
//   loader. ld_last and ld_data are meaningful only while ld_valid=1.
//   ld_ready does not depend on ld_valid.
//
//   Signals
//     ld_start  loader -> mem   pulse: begin (re)load at word 0
//     ld_valid  loader -> mem   beat valid
//     ld_data   loader -> mem   32-bit program word
//     ld_last   loader -> mem   final word of the program
//     ld_ready  mem -> loader   transfer allowed this cycle
//     ld_done   mem -> loader   program loaded, fetch enabled
//     words_ld  mem -> loader   words written by the last load (AW+1 bits)
//     if_req    core -> mem     fetch request, pc sampled this cycle
//     pc        core -> mem     byte address
//     if_stall  core -> mem     hold fetch output
//     if_valid  mem -> core     if_inst / if_fault valid
//     if_inst   mem -> core     fetched instruction
//     if_fault  mem -> core     misaligned / out-of-range / unloaded fetch
//     dbg_state mem -> observer FSM state (0 IDLE, 1 LOAD, 2 RUN)
//   AW must equal $clog2(DEPTH) of the connected memory.
// ---------------------------------------------------------------------------
interface imem_stream_loader_if #(
  parameter int AW = 9
);
  logic          ld_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   words_ld;
  logic          if_req;
  logic [31:0]   pc;
  logic          if_stall;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic          if_fault;
  logic [1:0]    dbg_state;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, if_req, pc, if_stall,
    input  ld_ready, ld_done, words_ld, if_valid, if_inst, if_fault, dbg_state
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, if_req, pc, if_stall,
    output ld_ready, ld_done, words_ld, if_valid, if_inst, if_fault, dbg_state
  );
endinterface

// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
//   Instruction memory filled by a 32-bit valid/ready stream and read by a
//   registered, byte-addressed fetch port with stall and fault reporting.
//   Sits between the boot/test loader and the IF stage.
//
//   Ports
//     clk    in   clock, all state on rising edge
//     reset  in   asynchronous, active-high
//     bus    slave modport of imem_stream_loader_if (loader + fetch port)
//
//   Parameters
//     DEPTH    words of storage (>= 2)
//     NOP_INST instruction returned on a faulted fetch
// ---------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int          DEPTH    = 320,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_stream_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [AW:0]   r_cnt;
  logic [AW:0]   r_words_ld;
  logic [31:0]   r_mem [DEPTH];

  logic          r_if_valid;
  logic [31:0]   r_if_inst;
  logic          r_if_fault;

  logic          w_ld_ready;
  logic          w_xfer;
  logic          w_wr_en;
  logic          w_end_beat;
  logic [29:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_fault;
  logic [31:0]   w_rd_data;
  logic          w_fetch;

  // -------------------------------------------------------------------------
  // Load handshake
  // -------------------------------------------------------------------------
  assign w_ld_ready = (r_state == S_LOAD);
  assign w_xfer     = bus.ld_valid & w_ld_ready;
  // ld_start restarts the load at word 0; a beat presented in the same
  // cycle is dropped so the restarted program begins cleanly.
  assign w_wr_en    = w_xfer & ~bus.ld_start;
  // A load ends on ld_last, or when the last storage word is written.
  assign w_end_beat = w_wr_en & (bus.ld_last | (r_cnt == (AW+1)'(DEPTH - 1)));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.ld_start) w_next = S_LOAD;
      S_LOAD: begin
        if (bus.ld_start)    w_next = S_LOAD;
        else if (w_end_beat) w_next = S_RUN;
      end
      S_RUN:  if (bus.ld_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Load counter and loaded-word count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_words_ld <= '0;
    end else if (bus.ld_start) begin
      r_cnt      <= '0;
      r_words_ld <= '0;
    end else if (w_wr_en) begin
      r_cnt      <= r_cnt + 1'b1;
      r_words_ld <= r_cnt + 1'b1;
    end
  end

  // Storage is intentionally not reset: words survive a reset, but fetches
  // fault until a new load sets words_ld again.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_cnt[AW-1:0]] <= bus.ld_data;
  end

  // -------------------------------------------------------------------------
  // Fetch
  // -------------------------------------------------------------------------
  assign w_word  = bus.pc[31:2];
  assign w_idx   = bus.pc[AW+1:2];
  assign w_fault = (bus.pc[1:0] != 2'b00)
                 | (w_word >= 30'(DEPTH))
                 | (w_word >= 30'(r_words_ld));
  // Index bits can exceed DEPTH-1 when DEPTH is not a power of two; those
  // addresses always fault, so steer the read to a legal word.
  assign w_rd_data = (32'(w_idx) < 32'(DEPTH)) ? r_mem[w_idx] : r_mem[0];
  // ld_start in RUN takes priority over a simultaneous fetch.
  assign w_fetch = (r_state == S_RUN) & bus.if_req & ~bus.ld_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      r_if_fault <= 1'b0;
    end else if (bus.if_stall) begin
      r_if_valid <= r_if_valid;
    end else if (w_fetch) begin
      r_if_valid <= 1'b1;
      r_if_fault <= w_fault;
      r_if_inst  <= w_fault ? NOP_INST : w_rd_data;
    end else begin
      r_if_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ld_ready  = w_ld_ready;
  assign bus.ld_done   = (r_state == S_RUN);
  assign bus.words_ld  = r_words_ld;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_inst   = r_if_inst;
  assign bus.if_fault  = r_if_fault;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;
  localparam int          DEPTH = 320;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  imem_stream_loader_if #(.AW(AW)) bus();

  imem_stream_loader #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: loaded program image and word count.
  logic [31:0] m_mem [DEPTH];
  int          m_words;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    check_val({tag, "_ld_done"},  32'(bus.ld_done),  32'd0);
    check_val({tag, "_words_ld"}, 32'(bus.words_ld), 32'd0);
    check_val({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
    check_val({tag, "_if_inst"},  bus.if_inst,       NOP);
    check_val({tag, "_if_fault"}, 32'(bus.if_fault), 32'd0);
  endtask

  function automatic logic exp_fault(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return (a[1:0] != 2'b00) || (w >= DEPTH) || (w >= m_words);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (exp_fault(a)) return NOP;
    return m_mem[a >> 2];
  endfunction

  // One-cycle ld_start pulse; a load begins with zero words.
  task automatic start_load();
    bus.ld_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ld_start = 1'b0;
    m_words = 0;
    check_val("start_ld_ready", 32'(bus.ld_ready), 32'd1);
    check_val("start_ld_done",  32'(bus.ld_done),  32'd0);
    check_val("start_words_ld", 32'(bus.words_ld), 32'd0);
  endtask

  // Streams n beats; idle cycles carry random data/last that must be ignored.
  task automatic send_words(input int n, input bit last_on_end, input bit toggle,
                            input bit rand_data, input logic [31:0] base);
    int sent = 0;
    int cyc  = 0;
    logic v;
    while (sent < n && cyc < 4 * n + 10) begin
      v = toggle ? cyc[0] : 1'b1;
      bus.ld_valid = v;
      bus.ld_data  = (rand_data || !v) ? $urandom : base + 32'(sent);
      bus.ld_last  = v ? (last_on_end && sent == n - 1) : 1'($urandom_range(0, 1));
      @(posedge clk);
      if (v) begin
        m_mem[m_words] = bus.ld_data;
        m_words++;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    if (sent < n) check_val("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] a, input bit run);
    bus.pc     = a;
    bus.if_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.pc     = $urandom;
    check_val({tag, "_valid"}, 32'(bus.if_valid), 32'(run));
    if (run) begin
      check_val({tag, "_inst"},  bus.if_inst,       exp_inst(a));
      check_val({tag, "_fault"}, 32'(bus.if_fault), 32'(exp_fault(a)));
    end
  endtask

  task automatic loaded_chk(input string tag);
    check_val({tag, "_ld_done"},  32'(bus.ld_done),  32'd1);
    check_val({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    check_val({tag, "_words_ld"}, 32'(bus.words_ld), 32'(m_words));
  endtask

  initial begin
    logic [31:0] held_inst;
    logic        held_fault;
    logic [31:0] a;

    reset        = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.if_req   = 1'b0;
    bus.pc       = '0;
    bus.if_stall = 1'b0;
    m_words      = 0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fetch before any load: no response.
    fetch_chk("idle_fetch", 32'h0, 1'b0);

    // 1: four words, ld_last on the fourth.
    start_load();
    send_words(4, 1'b1, 1'b0, 1'b0, 32'hA0);
    loaded_chk("t1");
    fetch_chk("t1_pc8", 32'h8, 1'b1);
    check_val("t1_inst_lit", bus.if_inst, 32'hA2);

    // 2: misaligned and unloaded fetches.
    fetch_chk("t2_pc6",  32'h6,  1'b1);
    fetch_chk("t2_pc10", 32'h10, 1'b1);
    check_val("t2_fault_lit", 32'(bus.if_fault), 32'd1);

    // 3: full-depth stream with gaps, forced end at DEPTH-1.
    start_load();
    send_words(DEPTH, 1'b0, 1'b1, 1'b1, 32'h0);
    loaded_chk("t3");
    check_val("t3_words_lit", 32'(bus.words_ld), 32'(DEPTH));
    bus.ld_valid = 1'b1;
    repeat (2) begin
      bus.ld_data = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    loaded_chk("t3_post");
    fetch_chk("t3_last",  32'(4 * (DEPTH - 1)), 1'b1);
    fetch_chk("t3_over",  32'(4 * DEPTH),       1'b1);
    fetch_chk("t3_first", 32'h0,                1'b1);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       a = {$urandom_range(0, DEPTH - 1), 2'b00};
        1:       a = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(1, 3))};
        2:       a = {$urandom_range(DEPTH, 1023), 2'b00};
        default: a = $urandom;
      endcase
      fetch_chk("t3_rand", a, 1'b1);
    end

    // 4: stall holds the fetch output while pc/if_req change.
    fetch_chk("t4_pc4", 32'h4, 1'b1);
    held_inst  = exp_inst(32'h4);
    held_fault = exp_fault(32'h4);
    for (int i = 0; i < 3; i++) begin
      bus.if_stall = 1'b1;
      bus.if_req   = 1'b1;
      bus.pc       = {$urandom_range(2, DEPTH - 1), 2'b00};
      @(posedge clk);
      @(negedge clk);
      check_val("t4_stall_valid", 32'(bus.if_valid), 32'd1);
      check_val("t4_stall_inst",  bus.if_inst,       held_inst);
      check_val("t4_stall_fault", 32'(bus.if_fault), 32'(held_fault));
    end
    bus.if_stall = 1'b0;
    fetch_chk("t4_release", 32'h8, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_val("t4_idle_valid", 32'(bus.if_valid), 32'd0);
    check_val("t4_idle_inst",  bus.if_inst,       exp_inst(32'h8));

    // 5: ld_start beats a same-cycle fetch, then a two-word reload.
    bus.ld_start = 1'b1;
    bus.if_req   = 1'b1;
    bus.pc       = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.if_req   = 1'b0;
    m_words      = 0;
    check_val("t5_valid",    32'(bus.if_valid), 32'd0);
    check_val("t5_ld_done",  32'(bus.ld_done),  32'd0);
    check_val("t5_words_ld", 32'(bus.words_ld), 32'd0);
    send_words(2, 1'b1, 1'b0, 1'b0, 32'hB0);
    loaded_chk("t5");
    fetch_chk("t5_pc0", 32'h0, 1'b1);
    check_val("t5_inst_lit", bus.if_inst, 32'hB0);
    fetch_chk("t5_pc8", 32'h8, 1'b1);

    // 6: asynchronous reset in the middle of a load.
    start_load();
    send_words(3, 1'b0, 1'b0, 1'b1, 32'h0);
    #2;
    reset   = 1'b1;
    m_words = 0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    reset = 1'b0;
    fetch_chk("t6_noload", 32'h0, 1'b0);
    start_load();
    send_words(1, 1'b1, 1'b0, 1'b1, 32'h0);
    loaded_chk("t6_reload");
    fetch_chk("t6_pc0", 32'h0, 1'b1);
    fetch_chk("t6_pc4", 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
